cb_dispatch: RTL and testbench
==============================

Name: cb_dispatch

Overview:
- Scheduler between the code-block segmentation output stream and NUM_LANES parallel turbo-encoder/interleaver lanes.
- Takes the segmented byte stream (data, start, size, filling and crc flags) and assigns each whole code block to one lane, using round-robin among lanes that are ready.
- Streams the block bytes to the granted lane with byte-level backpressure and marks the block's last byte.
- Detects framing errors: a missing start, or a start arriving in the middle of a block.

Parameters:
NUM_LANES, 2, number of downstream lanes (2..4)
K_PLUS_BYTES, 768, code-block length in bytes when in_size=1 (6144 bits)
K_MINUS_BYTES, 760, code-block length in bytes when in_size=0 (6080 bits)
CNT_W, 13, byte-counter width; must hold K_PLUS_BYTES-1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream byte valid
in_ready  out  1  byte accepted when in_valid&&in_ready
in_data  in  8  code-block byte
in_start  in  1  first byte of a code block
in_size  in  1  block size select, 1=K+, 0=K-; sampled with in_start
in_fill  in  1  byte is filler
in_crc  in  1  byte is CRC24
lane_ready  in  NUM_LANES  per-lane byte acceptance
lane_valid  out  NUM_LANES  one-hot byte valid to the granted lane
lane_data  out  8  broadcast byte bus
lane_start  out  1  first byte of block
lane_last  out  1  final byte of block
lane_fill  out  1  passthrough of in_fill
lane_crc  out  1  passthrough of in_crc
lane_size  out  1  latched size of the current block
lane_abort  out  1  one-cycle pulse: current lane block truncated
err_frame  out  1  one-cycle pulse on framing error
blk_cnt  out  16  completed blocks, wraps at 0xFFFF->0

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; grant=0; rr_ptr=NUM_LANES-1, so the first grant goes to lane 0.
  - cnt=0, len=0, blk_cnt=0.
  - All outputs 0.
  - Reset mid-block abandons the block silently: no lane_abort, no lane_last.
- FSM states: IDLE, ARB, STREAM.
- IDLE:
  - in_valid&&in_start: in_ready=0 (byte not consumed). Latch len = (in_size ? K_PLUS_BYTES : K_MINUS_BYTES), latch lane_size. Go to ARB.
  - in_valid&&!in_start: in_ready=1, byte dropped, err_frame=1 that cycle, stay in IDLE.
- ARB:
  - Pick the first i with lane_ready[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_LANES. Register grant=i; rr_ptr=i. Go to STREAM; cnt=0.
  - No lane ready: stay in ARB with in_ready=0.
  - Minimum IDLE-to-first-transfer latency: 2 cycles.
- STREAM (lane outputs are combinational from registered grant/cnt/len and the input; 0 added latency):
  - in_ready = lane_ready[grant].
  - lane_valid[grant] = in_valid && lane_ready[grant]; other lanes' lane_valid bits = 0.
  - lane_data/fill/crc follow the input.
  - lane_start = (cnt==0); lane_last = (cnt==len-1); both qualified by lane_valid.
  - On transfer: cnt++.
  - On transfer with lane_last: blk_cnt++, go to IDLE.
  - in_valid&&in_start&&cnt!=0: in_ready=0 (byte not consumed), lane_abort=1, err_frame=1 for one cycle, go to IDLE. The start byte is re-handled in IDLE on the next cycle.
  - in_start with cnt==0 is the legal first byte.
  - Upstream asserting in_start while the granted lane is stalled still aborts; the abort check does not depend on lane_ready.
  - A lane dropping lane_ready mid-block stalls only; it is never re-arbitrated.
- Arithmetic:
  - cnt is CNT_W bits unsigned; it never exceeds len-1.
  - blk_cnt is 16-bit modulo.
  - rr_ptr/grant are clog2(NUM_LANES) bits; wrap handled by modulo on the index.
- Idle outputs:
  - Outside STREAM, lane_valid=0; lane_start/lane_last = 0.
  - lane_data holds don't-care, but is driven 0 in IDLE/ARB for a clean trace.

Decomposition:
- Shared package cb_pkg:
  - state enum {IDLE, ARB, STREAM};
  - K_PLUS_BYTES / K_MINUS_BYTES constants, shared with the segmentation size computation;
  - CNT_W.
- Sub-module rr_arbiter (NUM_LANES request vector, rr_ptr in, one-hot/index grant out, purely combinational). It is reused by any future lane-sharing block.

Test Plan:
- NUM_LANES=2, both lanes ready. Two back-to-back K+ blocks (768 bytes each, in_start on byte 0) -> block 1 on lane 0, block 2 on lane 1. lane_start on byte 0 and lane_last on byte 767 of each; blk_cnt=2; in_ready low for 2 cycles between blocks.
- K- block with lane_ready[0]=0, lane_ready[1]=1, rr_ptr=1 -> lane 1 granted; lane_last on byte 759; lane_size=0.
- Lane 0 toggles lane_ready 1-0-1 every 3 cycles mid-block -> in_ready mirrors it; no bytes lost or duplicated (check sequence 0..767); grant unchanged.
- Both lanes not ready for 10 cycles after a start -> FSM held in ARB, in_ready=0. Lane 1 then rises -> grant=1, first byte transferred the next cycle.
- in_start asserted at byte 100 of a block -> lane_abort and err_frame pulse once; blk_cnt unchanged; the new block is arbitrated to the other lane and completes normally. Separately, a stray byte in IDLE without in_start -> dropped, err_frame=1.
- reset pulsed low at byte 300 of a block -> all outputs 0 immediately; after release, the next block goes to lane 0 and blk_cnt=0.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared definitions for the code-block dispatch path: FSM encoding and
// code-block byte lengths, also used by the segmentation size computation.
package cb_pkg;

  localparam int unsigned K_PLUS_BYTES  = 768;
  localparam int unsigned K_MINUS_BYTES = 760;
  localparam int unsigned CNT_W         = 13;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    STREAM
  } state_e;

endpackage

// File: rtl/cb_dispatch_if.sv
// Segmented byte stream in, broadcast lane bus out, plus status pulses.
interface cb_dispatch_if #(
  parameter int unsigned NUM_LANES = 2
);

  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 in_start;
  logic                 in_size;
  logic                 in_fill;
  logic                 in_crc;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_valid;
  logic [7:0]           lane_data;
  logic                 lane_start;
  logic                 lane_last;
  logic                 lane_fill;
  logic                 lane_crc;
  logic                 lane_size;
  logic                 lane_abort;
  logic                 err_frame;
  logic [15:0]          blk_cnt;

  modport master (
    output in_valid, in_data, in_start, in_size, in_fill, in_crc, lane_ready,
    input  in_ready, lane_valid, lane_data, lane_start, lane_last, lane_fill,
           lane_crc, lane_size, lane_abort, err_frame, blk_cnt
  );

  modport slave (
    input  in_valid, in_data, in_start, in_size, in_fill, in_crc, lane_ready,
    output in_ready, lane_valid, lane_data, lane_start, lane_last, lane_fill,
           lane_crc, lane_size, lane_abort, err_frame, blk_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_oh
);

  int unsigned   idx;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    idx       = 0;
    sel       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      sel = IW'(idx);
      if (!gnt_valid && req[sel]) begin
        gnt_valid   = 1'b1;
        gnt_idx     = sel;
        gnt_oh[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cb_dispatch.sv
// Assigns each whole code block to one ready lane (round-robin) and streams
// its bytes with backpressure, flagging missing or mid-block starts.
module cb_dispatch #(
  parameter int unsigned NUM_LANES     = 2,
  parameter int unsigned K_PLUS_BYTES  = cb_pkg::K_PLUS_BYTES,
  parameter int unsigned K_MINUS_BYTES = cb_pkg::K_MINUS_BYTES,
  parameter int unsigned CNT_W         = cb_pkg::CNT_W
) (
  input logic          clk,
  input logic          reset,
  cb_dispatch_if.slave bus
);

  import cb_pkg::*;

  localparam int unsigned GW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [NUM_LANES-1:0] grant_oh_q, grant_oh_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic                 size_q, size_d;
  logic [15:0]          blk_cnt_q, blk_cnt_d;

  logic                 arb_valid;
  logic [GW-1:0]        arb_idx;
  logic [NUM_LANES-1:0] arb_oh;

  logic                 abort, xfer, is_last;

  rr_arbiter #(.N(NUM_LANES)) u_arb (
    .req       (bus.lane_ready),
    .ptr       (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx),
    .gnt_oh    (arb_oh)
  );

  // A start on a non-first byte wins over transfer, whatever the lane's ready.
  always_comb begin
    abort   = (state_q == STREAM) && bus.in_valid && bus.in_start && (cnt_q != '0);
    xfer    = (state_q == STREAM) && !abort && bus.in_valid && bus.lane_ready[grant_q];
    is_last = (cnt_q == (len_q - CNT_W'(1)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= GW'(NUM_LANES - 1);
      cnt_q      <= '0;
      len_q      <= '0;
      size_q     <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      size_q     <= size_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    size_d     = size_q;
    blk_cnt_d  = blk_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_start) begin
          len_d   = bus.in_size ? CNT_W'(K_PLUS_BYTES) : CNT_W'(K_MINUS_BYTES);
          size_d  = bus.in_size;
          state_d = ARB;
        end
      end
      ARB: begin
        if (arb_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          rr_ptr_d   = arb_idx;
          cnt_d      = '0;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (is_last) begin
            cnt_d     = '0;
            blk_cnt_d = blk_cnt_q + 16'd1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = 1'b0;
    bus.lane_valid = '0;
    bus.lane_data  = '0;
    bus.lane_start = 1'b0;
    bus.lane_last  = 1'b0;
    bus.lane_fill  = 1'b0;
    bus.lane_crc   = 1'b0;
    bus.lane_size  = size_q;
    bus.lane_abort = 1'b0;
    bus.err_frame  = 1'b0;
    bus.blk_cnt    = blk_cnt_q;
    unique case (state_q)
      IDLE: begin
        bus.in_ready  = bus.in_valid && !bus.in_start;
        bus.err_frame = bus.in_valid && !bus.in_start;
      end
      ARB: ;
      STREAM: begin
        if (abort) begin
          bus.lane_abort = 1'b1;
          bus.err_frame  = 1'b1;
        end else begin
          bus.in_ready   = bus.lane_ready[grant_q];
          bus.lane_valid = xfer ? grant_oh_q : '0;
          bus.lane_data  = bus.in_data;
          bus.lane_fill  = bus.in_fill;
          bus.lane_crc   = bus.in_crc;
          bus.lane_start = xfer && (cnt_q == '0);
          bus.lane_last  = xfer && is_last;
        end
      end
      default: ;
    endcase
    // Combinational outputs are forced low while reset is held, not just after it.
    if (!reset) begin
      bus.in_ready   = 1'b0;
      bus.lane_valid = '0;
      bus.lane_data  = '0;
      bus.lane_start = 1'b0;
      bus.lane_last  = 1'b0;
      bus.lane_fill  = 1'b0;
      bus.lane_crc   = 1'b0;
      bus.lane_size  = 1'b0;
      bus.lane_abort = 1'b0;
      bus.err_frame  = 1'b0;
      bus.blk_cnt    = '0;
    end
  end

endmodule

// File: tb/tb_cb_dispatch.sv
// Directed bench for cb_dispatch with two lanes: a per-cycle vector table for
// the handshake/error cases, plus full-block streaming sequences.
module tb_cb_dispatch;

  localparam int unsigned NL = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  cb_dispatch_if #(.NUM_LANES(NL)) bus ();

  cb_dispatch #(
    .NUM_LANES     (NL),
    .K_PLUS_BYTES  (768),
    .K_MINUS_BYTES (760),
    .CNT_W         (13)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         rep;
    logic       valid;
    logic       start;
    logic       size;
    logic [7:0] data;
    logic [1:0] lr;
    logic       exp_ready;
    logic [1:0] exp_lv;
    logic       exp_start;
    logic       exp_last;
    logic       exp_err;
    logic       exp_abort;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic sz, input logic [7:0] d,
                       input logic f, input logic c, input logic [1:0] lr);
    bus.in_valid   = v;
    bus.in_start   = s;
    bus.in_size    = sz;
    bus.in_data    = d;
    bus.in_fill    = f;
    bus.in_crc     = c;
    bus.lane_ready = lr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.in_ready, bus.lane_valid, bus.lane_data, bus.lane_start, bus.lane_last,
                bus.lane_fill, bus.lane_crc, bus.lane_size, bus.lane_abort, bus.err_frame,
                bus.blk_cnt});
  endfunction

  // Presents bytes first..stop_at-1 of a block; byte i carries i^0x5A, fill on
  // bytes 0-1, crc on the final three. Every cycle is checked against the model.
  task automatic stream_block(input logic sz, input logic exp_lane, input int first,
                              input int stop_at, input logic [1:0] lr_base, input bit toggle0,
                              output int lat, output int errs);
    int         len;
    int         i;
    int         cyc;
    int         tcnt;
    bit         started;
    logic [1:0] lr;
    logic [1:0] exp_oh;
    logic [7:0] d;
    logic       xfer;
    len     = sz ? 768 : 760;
    i       = first;
    cyc     = 0;
    tcnt    = 0;
    started = (first > 0);
    lat     = 0;
    errs    = 0;
    exp_oh  = exp_lane ? 2'b10 : 2'b01;
    while (i < stop_at && cyc < 5000) begin
      lr = lr_base;
      if (toggle0 && started) lr[0] = ((tcnt / 3) % 2 == 0);
      d = 8'(i) ^ 8'h5A;
      drive(1'b1, i == 0, sz, d, i < 2, i >= len - 3, lr);
      #2;
      xfer = bus.in_ready;
      if (bus.lane_abort !== 1'b0 || bus.err_frame !== 1'b0) errs++;
      if (started && bus.in_ready !== lr[exp_lane]) errs++;
      if (bus.lane_valid !== (xfer ? exp_oh : 2'b00)) errs++;
      if (xfer) begin
        if ({bus.lane_data, bus.lane_start, bus.lane_last, bus.lane_fill, bus.lane_crc,
             bus.lane_size} !== {d, i == 0, i == len - 1, i < 2, i >= len - 3, sz}) errs++;
        i++;
        started = 1'b1;
      end else if (!started) begin
        lat++;
      end
      if (started) tcnt++;
      next_cycle();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    if (cyc >= 5000) errs++;
  endtask

  initial begin
    vec_t vecs[14];
    int   lat;
    int   errs;

    vecs[0]  = '{1,  1'b0, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,  1'b1, 1'b0, 1'b0, 8'hAA, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1,  1'b1, 1'b1, 1'b1, 8'h11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{10, 1'b1, 1'b1, 1'b1, 8'h11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1,  1'b1, 1'b1, 1'b1, 8'h11, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1,  1'b1, 1'b1, 1'b1, 8'h11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1,  1'b1, 1'b0, 1'b1, 8'h12, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1,  1'b1, 1'b0, 1'b1, 8'h13, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1,  1'b1, 1'b0, 1'b1, 8'h13, 2'b11, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1,  1'b0, 1'b0, 1'b1, 8'h00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1,  1'b1, 1'b1, 1'b0, 8'h5A, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1,  1'b1, 1'b1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1,  1'b1, 1'b1, 1'b0, 8'h5A, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1,  1'b1, 1'b1, 1'b0, 8'h5A, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};

    drive(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 2'b11);
    repeat (2) next_cycle();
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b1;

    // Stray byte, start held through a 10-cycle ARB stall, lane-1 grant,
    // mid-block stall, mid-block start abort, then re-arbitration to lane 0.
    for (int v = 0; v < 14; v++) begin
      for (int r = 0; r < vecs[v].rep; r++) begin
        drive(vecs[v].valid, vecs[v].start, vecs[v].size, vecs[v].data, 1'b0, 1'b0, vecs[v].lr);
        #2;
        chk($sformatf("vec%0d", v),
            64'({bus.in_ready, bus.lane_valid, bus.lane_start, bus.lane_last, bus.err_frame, bus.lane_abort}),
            64'({vecs[v].exp_ready, vecs[v].exp_lv, vecs[v].exp_start, vecs[v].exp_last,
                 vecs[v].exp_err, vecs[v].exp_abort}));
        next_cycle();
      end
    end
    stream_block(1'b0, 1'b0, 1, 760, 2'b11, 1'b0, lat, errs);
    chk("tbl_tail_errs", 64'(errs), 64'd0);
    chk("tbl_blk_cnt", 64'(bus.blk_cnt), 64'd1);

    reset = 1'b0;
    next_cycle();
    reset = 1'b1;

    stream_block(1'b1, 1'b0, 0, 768, 2'b11, 1'b0, lat, errs);
    chk("kplus_a_errs", 64'(errs), 64'd0);
    chk("kplus_a_lat", 64'(lat), 64'd2);
    stream_block(1'b1, 1'b1, 0, 768, 2'b11, 1'b0, lat, errs);
    chk("kplus_b_errs", 64'(errs), 64'd0);
    chk("kplus_b_lat", 64'(lat), 64'd2);
    chk("kplus_blk_cnt", 64'(bus.blk_cnt), 64'd2);

    stream_block(1'b0, 1'b1, 0, 760, 2'b10, 1'b0, lat, errs);
    chk("kminus_errs", 64'(errs), 64'd0);
    chk("kminus_lat", 64'(lat), 64'd2);
    chk("kminus_blk_cnt", 64'(bus.blk_cnt), 64'd3);

    stream_block(1'b1, 1'b0, 0, 768, 2'b11, 1'b1, lat, errs);
    chk("toggle_errs", 64'(errs), 64'd0);
    chk("toggle_blk_cnt", 64'(bus.blk_cnt), 64'd4);

    stream_block(1'b1, 1'b1, 0, 100, 2'b11, 1'b0, lat, errs);
    chk("pre_abort_errs", 64'(errs), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'b11);
    #2;
    chk("abort_cycle", 64'({bus.in_ready, bus.lane_valid, bus.lane_abort, bus.err_frame}),
        64'({1'b0, 2'b00, 1'b1, 1'b1}));
    chk("abort_blk_cnt", 64'(bus.blk_cnt), 64'd4);
    next_cycle();
    stream_block(1'b1, 1'b0, 0, 768, 2'b11, 1'b0, lat, errs);
    chk("post_abort_errs", 64'(errs), 64'd0);
    chk("post_abort_lat", 64'(lat), 64'd2);
    chk("post_abort_blk_cnt", 64'(bus.blk_cnt), 64'd5);

    stream_block(1'b1, 1'b0, 0, 300, 2'b01, 1'b0, lat, errs);
    chk("pre_reset_errs", 64'(errs), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 8'(300) ^ 8'h5A, 1'b0, 1'b0, 2'b01);
    #2;
    chk("pre_reset_xfer", 64'(bus.lane_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk("reset_mid_outs", all_outs(), 64'd0);
    bus.in_valid = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #1;
    chk("post_reset_blk_cnt", 64'(bus.blk_cnt), 64'd0);
    stream_block(1'b1, 1'b0, 0, 768, 2'b11, 1'b0, lat, errs);
    chk("post_reset_errs", 64'(errs), 64'd0);
    chk("post_reset_lat", 64'(lat), 64'd2);
    chk("post_reset_blk_cnt2", 64'(bus.blk_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
